// File: rtl/mc_control_fsm_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller.
// master = controller side, slave = datapath side.
interface mc_control_fsm_if #(
  parameter int COUNT_W = 32,
  parameter int STATE_W = 4
);
  logic               run;
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               regwrite;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  run, opcode, mem_ready,
    output pc_write, pc_write_cond, iord,
    output mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, regwrite,
    output alu_src_a, alu_src_b, alu_op,
    output pc_source, halted,
    output instr_count, state_dbg
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_write, pc_write_cond, iord,
    input  mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dst, regwrite,
    input  alu_src_a, alu_src_b, alu_op,
    input  pc_source, halted,
    input  instr_count, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: one state per datapath step,
// memory-ready stalls, sticky halt, retired-instruction counter.
module mc_control_fsm #(
  parameter int COUNT_W = 32,
  parameter int STATE_W = 4
) (
  input logic clk,
  input logic rst_n,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_RD    = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WR    = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EXEC = 4'd11,
    ADDI_WB   = 4'd12,
    HALT      = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t             state;
  state_t             nxt;
  logic               retire;
  logic [COUNT_W-1:0] count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (retire) count <= count + 1'b1;
  end

  // Next-state and control decode.
  always_comb begin
    nxt               = state;
    retire            = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.regwrite      = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.halted        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.run) nxt = FETCH;
      end
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) nxt = DECODE;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_R:    nxt = R_EXEC;
          OP_LW:   nxt = MEM_ADDR;
          OP_SW:   nxt = MEM_ADDR;
          OP_BEQ:  nxt = BRANCH;
          OP_J:    nxt = JUMP;
          OP_ADDI: nxt = ADDI_EXEC;
          default: nxt = HALT;
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        nxt = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        bus.regwrite   = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        retire        = bus.mem_ready;
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        nxt           = R_WB;
      end
      R_WB: begin
        bus.regwrite = 1'b1;
        bus.reg_dst  = 1'b1;
        retire       = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        retire            = 1'b1;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        retire        = 1'b1;
      end
      ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        nxt           = ADDI_WB;
      end
      ADDI_WB: begin
        bus.regwrite = 1'b1;
        retire       = 1'b1;
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (retire) nxt = bus.run ? FETCH : IDLE;
  end

  assign bus.instr_count = count;
  assign bus.state_dbg   = STATE_W'(state);

endmodule
